// File: rtl/digital_calendar_pkg.sv
// -----------------------------------------------------------------------------
// digital_calendar_pkg
// Shared constants for the calendar date counter: field widths, month
// encodings (JAN..DEC, 1-based) and the base (non-leap) month-length table.
// -----------------------------------------------------------------------------
package digital_calendar_pkg;

  localparam int YEAR_W  = 7;
  localparam int MONTH_W = 5;
  localparam int DAY_W   = 5;

  localparam logic [MONTH_W-1:0] JAN = 5'd1;
  localparam logic [MONTH_W-1:0] FEB = 5'd2;
  localparam logic [MONTH_W-1:0] MAR = 5'd3;
  localparam logic [MONTH_W-1:0] APR = 5'd4;
  localparam logic [MONTH_W-1:0] MAY = 5'd5;
  localparam logic [MONTH_W-1:0] JUN = 5'd6;
  localparam logic [MONTH_W-1:0] JUL = 5'd7;
  localparam logic [MONTH_W-1:0] AUG = 5'd8;
  localparam logic [MONTH_W-1:0] SEP = 5'd9;
  localparam logic [MONTH_W-1:0] OCT = 5'd10;
  localparam logic [MONTH_W-1:0] NOV = 5'd11;
  localparam logic [MONTH_W-1:0] DEC = 5'd12;

  // Last day of a month ignoring leap years. Unreachable month codes map to
  // 31 so the table is total; the counter never produces them.
  function automatic logic [DAY_W-1:0] base_days(input logic [MONTH_W-1:0] m);
    case (m)
      FEB:                base_days = 5'd28;
      APR, JUN, SEP, NOV: base_days = 5'd30;
      default:            base_days = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/digital_calendar_days_in_month.sv
// -----------------------------------------------------------------------------
// days_in_month
// Combinational last-day-of-month lookup.
//   month    [4:0] in  : current month, 1..12
//   year     [6:0] in  : year offset from 2000
//   last_day [4:0] out : number of days in that month
// Macro DIGITAL_CALENDAR_LEAP_EN: when defined, February has 29 days in years
// whose offset is a multiple of 4 (2000 included); otherwise always 28.
// -----------------------------------------------------------------------------
module days_in_month
  import digital_calendar_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   last_day
);

`ifdef DIGITAL_CALENDAR_LEAP_EN
  logic leap;

  // Offsets 0..127 span 2000..2127, where the divisible-by-100 rule only
  // touches 2100; offset 100 is beyond the default wrap, so mod-4 suffices.
  assign leap = (year[1:0] == 2'b00);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    last_day = base_days(month);
    if (month == FEB && leap) last_day = 5'd29;
  end
`else
  // Year is irrelevant without leap support; fold it into a sink signal.
  logic unused_year;
  assign unused_year = ^year;

  always_comb begin
    last_day = base_days(month);
  end
`endif

endmodule

// File: rtl/digital_calendar.sv
// -----------------------------------------------------------------------------
// digital_calendar
// Free-running date counter advancing one day per day-tick.
//   clk         in  : system clock, rising edge active
//   reset       in  : asynchronous, active-high; forces 2000-01-01
//   year  [6:0] out : offset from 2000, 0..YEAR_MAX
//   month [4:0] out : 1..12
//   day   [4:0] out : 1..31
// Parameters: TICKS_PER_DAY (>=1) clk edges per day, YEAR_MAX (0..127).
// Macro DIGITAL_CALENDAR_LEAP_EN enables 29-day February in leap years.
// -----------------------------------------------------------------------------
module digital_calendar
  import digital_calendar_pkg::*;
#(
  parameter int TICKS_PER_DAY = 1,
  parameter int YEAR_MAX      = 99
) (
  input  logic               clk,
  input  logic               reset,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day
);

  localparam logic [YEAR_W-1:0] YEAR_LAST = YEAR_W'(YEAR_MAX);

  logic             day_tick;
  logic [DAY_W-1:0] last_day;

  // ---------------------------------------------------------------------------
  // Prescaler: day_tick is high on the edge where the count is at its last
  // value, so the first edge after reset is count 0.
  // ---------------------------------------------------------------------------
  generate
    if (TICKS_PER_DAY == 1) begin : g_no_prescale
      assign day_tick = 1'b1;
    end else begin : g_prescale
      localparam int CNT_W = $clog2(TICKS_PER_DAY);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DAY - 1);

      logic [CNT_W-1:0] cnt;

      assign day_tick = (cnt == CNT_LAST);

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)         cnt <= '0;
        else if (day_tick) cnt <= '0;
        else               cnt <= cnt + 1'b1;
      end
    end
  endgenerate

  days_in_month u_days_in_month (
    .month    (month),
    .year     (year),
    .last_day (last_day)
  );

  // ---------------------------------------------------------------------------
  // Date registers drive the outputs directly, so an update is visible right
  // after its tick edge and only legal dates can appear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      year  <= '0;
      month <= JAN;
      day   <= 5'd1;
    end else if (day_tick) begin
      if (day < last_day) begin
        day <= day + 1'b1;
      end else begin
        day <= 5'd1;
        if (month < DEC) begin
          month <= month + 1'b1;
        end else begin
          month <= JAN;
          year  <= (year == YEAR_LAST) ? '0 : year + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_digital_calendar.sv
// -----------------------------------------------------------------------------
// tb_digital_calendar
// Directed checks of the date counter: reset, month rollover, February
// handling (leap-aware when DIGITAL_CALENDAR_LEAP_EN is defined), year wrap,
// asynchronous mid-count reset and a TICKS_PER_DAY=4 prescaler instance.
// -----------------------------------------------------------------------------
module tb_digital_calendar;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] year,  year4;
  logic [4:0] month, month4;
  logic [4:0] day,   day4;

  int total = 0;
  int bad   = 0;

`ifdef DIGITAL_CALENDAR_LEAP_EN
  localparam int         YEAR0_DAYS = 366;
  localparam int         WRAP_DAYS  = 36525;  // 25 leap years in 2000..2099
  localparam logic [4:0] F28P1_M = 5'd2, F28P1_D = 5'd29;
  localparam logic [4:0] F28P2_M = 5'd3, F28P2_D = 5'd1;
  localparam logic [4:0] D100_D  = 5'd10;     // Jan 1 + 100 days = Apr 10
`else
  localparam int         YEAR0_DAYS = 365;
  localparam int         WRAP_DAYS  = 36500;
  localparam logic [4:0] F28P1_M = 5'd3, F28P1_D = 5'd1;
  localparam logic [4:0] F28P2_M = 5'd3, F28P2_D = 5'd2;
  localparam logic [4:0] D100_D  = 5'd11;     // Jan 1 + 100 days = Apr 11
`endif

  digital_calendar dut (
    .clk   (clk),
    .reset (reset),
    .year  (year),
    .month (month),
    .day   (day)
  );

  digital_calendar #(.TICKS_PER_DAY(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .year  (year4),
    .month (month4),
    .day   (day4)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 10 ns reset pulse starting just after an edge; the next edge after release
  // is prescaler edge 0.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #10 reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd1}) begin
      bad++;
      $display("FAIL reset_async: got %0d/%0d/%0d want 0/1/1", year, month, day);
    end
    @(posedge clk); #1;
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd1}) begin
      bad++;
      $display("FAIL reset_hold: got %0d/%0d/%0d want 0/1/1", year, month, day);
    end
    #6 reset = 1'b0;
    step(10);
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd11}) begin
      bad++;
      $display("FAIL reset_10edges: got %0d/%0d/%0d want 0/1/11", year, month, day);
    end
  endtask

  task automatic test_month_rollover();
    do_reset();
    step(30);
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd31}) begin
      bad++;
      $display("FAIL jan31: got %0d/%0d/%0d want 0/1/31", year, month, day);
    end
    step(1);
    total++;
    if ({year, month, day} !== {7'd0, 5'd2, 5'd1}) begin
      bad++;
      $display("FAIL feb1: got %0d/%0d/%0d want 0/2/1", year, month, day);
    end
  endtask

  task automatic test_february();
    do_reset();
    step(58);
    total++;
    if ({year, month, day} !== {7'd0, 5'd2, 5'd28}) begin
      bad++;
      $display("FAIL y0_feb28: got %0d/%0d/%0d want 0/2/28", year, month, day);
    end
    step(1);
    total++;
    if ({year, month, day} !== {7'd0, F28P1_M, F28P1_D}) begin
      bad++;
      $display("FAIL y0_feb28p1: got %0d/%0d/%0d want 0/%0d/%0d",
               year, month, day, F28P1_M, F28P1_D);
    end
    step(1);
    total++;
    if ({year, month, day} !== {7'd0, F28P2_M, F28P2_D}) begin
      bad++;
      $display("FAIL y0_feb28p2: got %0d/%0d/%0d want 0/%0d/%0d",
               year, month, day, F28P2_M, F28P2_D);
    end
    do_reset();
    step(YEAR0_DAYS + 58);
    total++;
    if ({year, month, day} !== {7'd1, 5'd2, 5'd28}) begin
      bad++;
      $display("FAIL y1_feb28: got %0d/%0d/%0d want 1/2/28", year, month, day);
    end
    step(1);
    total++;
    if ({year, month, day} !== {7'd1, 5'd3, 5'd1}) begin
      bad++;
      $display("FAIL y1_mar1: got %0d/%0d/%0d want 1/3/1", year, month, day);
    end
  endtask

  task automatic test_year_wrap();
    do_reset();
    step(WRAP_DAYS - 1);
    total++;
    if ({year, month, day} !== {7'd99, 5'd12, 5'd31}) begin
      bad++;
      $display("FAIL y99_dec31: got %0d/%0d/%0d want 99/12/31", year, month, day);
    end
    step(1);
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd1}) begin
      bad++;
      $display("FAIL year_wrap: got %0d/%0d/%0d want 0/1/1", year, month, day);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(100);
    total++;
    if ({year, month, day} !== {7'd0, 5'd4, D100_D}) begin
      bad++;
      $display("FAIL d100: got %0d/%0d/%0d want 0/4/%0d", year, month, day, D100_D);
    end
    // clk is high here: assert reset between edges and expect an immediate clear.
    #1 reset = 1'b1;
    #1;
    total++;
    if ({year, month, day, year4, month4, day4} !==
        {7'd0, 5'd1, 5'd1, 7'd0, 5'd1, 5'd1}) begin
      bad++;
      $display("FAIL midreset_async: got %0d/%0d/%0d p4 %0d/%0d/%0d want 0/1/1 both",
               year, month, day, year4, month4, day4);
    end
    @(posedge clk); #1;
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd1}) begin
      bad++;
      $display("FAIL midreset_hold: got %0d/%0d/%0d want 0/1/1", year, month, day);
    end
    #11 reset = 1'b0;  // 20 ns pulse, released while clk is high
    step(1);
    total++;
    if ({year, month, day} !== {7'd0, 5'd1, 5'd2}) begin
      bad++;
      $display("FAIL midreset_resume: got %0d/%0d/%0d want 0/1/2", year, month, day);
    end
    step(3);
    total++;
    if ({day, day4} !== {5'd5, 5'd2}) begin
      bad++;
      $display("FAIL midreset_4edges: got day=%0d day4=%0d want day=5 day4=2", day, day4);
    end
  endtask

  task automatic test_prescaler();
    do_reset();
    step(3);
    total++;
    if ({year4, month4, day4} !== {7'd0, 5'd1, 5'd1}) begin
      bad++;
      $display("FAIL presc_3edges: got %0d/%0d/%0d want 0/1/1", year4, month4, day4);
    end
    step(1);
    total++;
    if (day4 !== 5'd2) begin
      bad++;
      $display("FAIL presc_4edges: got day4=%0d want 2", day4);
    end
    step(3);
    total++;
    if (day4 !== 5'd2) begin
      bad++;
      $display("FAIL presc_7edges: got day4=%0d want 2", day4);
    end
    step(1);
    total++;
    if ({year4, month4, day4} !== {7'd0, 5'd1, 5'd3}) begin
      bad++;
      $display("FAIL presc_8edges: got %0d/%0d/%0d want 0/1/3", year4, month4, day4);
    end
  endtask

  initial begin
    test_reset();
    test_month_rollover();
    test_february();
    test_prescaler();
    test_mid_reset();
    test_year_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
